line_mem_ctrl: RTL

- Main-memory controller directly downstream of the direct-mapped write-back cache.
- Services the cache miss path:
  - accepts one line request at a time;
  - optionally writes back a dirty 16-word victim line;
  - then streams the 16-word fill line back to the cache, one word per cycle.
- Owns the main-memory array: 8192 blocks x 16 words x 32 bits.
- Replaces single-cycle, whole-line memory copies with a timed, handshaked burst interface.

---
 rtl/line_mem_pkg.sv | 23 ++
 rtl/line_mem_array.sv | 38 +++
 rtl/line_mem_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/line_mem_pkg.sv
// Shared encodings and sizes for the line memory controller and its word array.
package line_mem_pkg;

  localparam int BLK_W          = 13;
  localparam int OFF_W          = 4;
  localparam int DATA_W         = 32;
  localparam int WORDS_PER_LINE = 16;

  localparam logic [1:0] OP_FILL    = 2'b00;
  localparam logic [1:0] OP_WB      = 2'b01;
  localparam logic [1:0] OP_WB_FILL = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_WAIT,
    ST_WB_BURST,
    ST_FILL_WAIT,
    ST_FILL_BURST,
    ST_DONE
  } state_t;

endpackage

// File: rtl/line_mem_array.sv
// Main-memory word store, {blk, off} addressed, 1 read + 1 write port, registered read.
// Preloaded with mem[b][w] = w; a same-address write and read returns the new word.
module line_mem_array
  import line_mem_pkg::*;
#(
  parameter int NUM_BLOCKS = 8192
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BLK_W-1:0]  wr_blk,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BLK_W-1:0]  rd_blk,
  input  logic [OFF_W-1:0]  rd_off,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = NUM_BLOCKS * WORDS_PER_LINE;

  logic [DATA_W-1:0]      mem [DEPTH];
  logic [BLK_W+OFF_W-1:0] wr_addr;
  logic [BLK_W+OFF_W-1:0] rd_addr;

  assign wr_addr = {wr_blk, wr_off};
  assign rd_addr = {rd_blk, rd_off};

  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = DATA_W'(a % WORDS_PER_LINE);
  end

  // Write-first bypass keeps a fill that starts on the last victim word coherent.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (we && (wr_addr == rd_addr)) rd_data <= wr_data;
    else                            rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/line_mem_ctrl.sv
// Cache miss-path controller: optional 16-word victim write-back, then a 16-word fill burst.
// CRITICAL_WORD_FIRST_EN: fill starts at the requested word and wraps; otherwise starts at 0.
//
// state         | meaning
// ST_IDLE       | ready for a request
// ST_WB_WAIT    | memory latency before victim burst
// ST_WB_BURST   | one victim word written per cycle, wb_idx 0..15
// ST_FILL_WAIT  | memory latency before fill burst
// ST_FILL_BURST | one fill word presented per cycle
// ST_DONE       | single-cycle completion pulse
module line_mem_ctrl
  import line_mem_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int NUM_BLOCKS  = 8192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [BLK_W-1:0]  req_fill_blk,
  input  logic [BLK_W-1:0]  req_wb_blk,
  input  logic [OFF_W-1:0]  req_word,
  output logic [OFF_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  output logic              fill_valid,
  output logic [OFF_W-1:0]  fill_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic              done,
  output logic              busy
);

  localparam int LAT_W = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = (MEM_LATENCY > 0) ? LAT_W'(MEM_LATENCY - 1) : '0;
  localparam state_t WB_ENTRY   = (MEM_LATENCY == 0) ? ST_WB_BURST   : ST_WB_WAIT;
  localparam state_t FILL_ENTRY = (MEM_LATENCY == 0) ? ST_FILL_BURST : ST_FILL_WAIT;

`ifdef CRITICAL_WORD_FIRST_EN
  localparam logic [OFF_W-1:0] START_MASK = '1;
`else
  localparam logic [OFF_W-1:0] START_MASK = '0;
`endif

  state_t             state, state_n;
  logic [1:0]         op_r;
  logic [BLK_W-1:0]   fill_blk_r, wb_blk_r;
  logic [OFF_W-1:0]   word_r;
  logic [OFF_W-1:0]   cnt, cnt_inc, start_off;
  logic [LAT_W-1:0]   lat_cnt;
  logic               mem_we;
  logic [BLK_W-1:0]   rd_blk;
  logic [OFF_W-1:0]   rd_off;
  logic [DATA_W-1:0]  rd_data;

  assign cnt_inc   = cnt + 1'b1;
  // In IDLE the request is still on the inputs, so a zero-latency fill can prefetch from them.
  assign start_off = ((state == ST_IDLE) ? req_word : word_r) & START_MASK;

  always_comb begin
    state_n = state;
    mem_we  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_FILL:           state_n = FILL_ENTRY;
            OP_WB, OP_WB_FILL: state_n = WB_ENTRY;
            default:           state_n = ST_DONE;
          endcase
        end
      end
      ST_WB_WAIT:   if (lat_cnt == '0) state_n = ST_WB_BURST;
      ST_WB_BURST: begin
        mem_we = 1'b1;
        if (cnt == '1) state_n = (op_r == OP_WB_FILL) ? FILL_ENTRY : ST_DONE;
      end
      ST_FILL_WAIT:  if (lat_cnt == '0) state_n = ST_FILL_BURST;
      ST_FILL_BURST: if (cnt_inc == start_off) state_n = ST_DONE;
      ST_DONE:       state_n = ST_IDLE;
      default:       state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_r       <= OP_FILL;
      fill_blk_r <= '0;
      wb_blk_r   <= '0;
      word_r     <= '0;
      cnt        <= '0;
      lat_cnt    <= '0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && req_valid) begin
        op_r       <= req_op;
        fill_blk_r <= req_fill_blk;
        wb_blk_r   <= req_wb_blk;
        word_r     <= req_word;
      end
      if ((state_n == ST_WB_WAIT && state != ST_WB_WAIT) ||
          (state_n == ST_FILL_WAIT && state != ST_FILL_WAIT))
        lat_cnt <= LAT_LOAD;
      else if (lat_cnt != '0)
        lat_cnt <= lat_cnt - 1'b1;
      if (state_n == ST_WB_BURST && state != ST_WB_BURST)
        cnt <= '0;
      else if (state_n == ST_FILL_BURST && state != ST_FILL_BURST)
        cnt <= start_off;
      else if (state == ST_WB_BURST || state == ST_FILL_BURST)
        cnt <= cnt_inc;
    end
  end

  // Read address runs one word ahead of the fill beat because the array read is registered.
  assign rd_blk = (state == ST_IDLE) ? req_fill_blk : fill_blk_r;
  assign rd_off = (state == ST_FILL_BURST) ? cnt_inc : start_off;

  line_mem_array #(.NUM_BLOCKS(NUM_BLOCKS)) u_array (
    .clk     (clk),
    .we      (mem_we),
    .wr_blk  (wb_blk_r),
    .wr_off  (cnt),
    .wr_data (wb_data),
    .rd_blk  (rd_blk),
    .rd_off  (rd_off),
    .rd_data (rd_data)
  );

  assign req_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign fill_valid = (state == ST_FILL_BURST);
  assign fill_idx   = fill_valid ? cnt : '0;
  assign wb_idx     = (state == ST_WB_BURST) ? cnt : '0;
  assign fill_data  = fill_valid ? rd_data : '0;

endmodule
